// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
// Memory-side responder for the LC-3b mem_read/mem_write/mem_resp handshake.
// It models a word-organised RAM with byte-write masking and a fixed response
// latency. It also provides a sticky protocol-error flag and a counter of
// completed transactions.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for mem_read or mem_write; a request is accepted here
// WAIT  | latency countdown; the cnt terminal count moves to RESP
// RESP  | one-cycle mem_resp pulse; request lines are not sampled
//
// Ports:
//   clk             clock; all state changes on the rising edge
//   rst_n           synchronous active-low reset
//   mem_read        read request
//   mem_write       write request
//   mem_byte_enable write mask (bit0 -> [7:0], bit1 -> [15:8])
//   mem_address     byte address; word index is mem_address[ADDR_BITS:1]
//   mem_wdata       write data
//   mem_resp        one-cycle completion pulse (registered)
//   mem_rdata       read data; held until the next read completes (registered)
//   proto_err       sticky protocol-violation flag
//   xact_count      completed-transaction count, wraps at 0xFFFF
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err,
  output logic [15:0] xact_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam bit         LAT1     = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic                 op_wr;
  logic [ADDR_BITS-1:0] op_idx;
  logic [15:0]          op_wdata;
  logic [1:0]           op_be;
  logic [15:0]          mem_array [DEPTH];

  logic                 req;
  logic                 accept;
  logic                 complete;
  logic                 c_wr;
  logic [ADDR_BITS-1:0] c_idx;
  logic [15:0]          c_wdata;
  logic [1:0]           c_be;

  assign req    = mem_read | mem_write;
  assign accept = (state == ST_IDLE) && req;

  // The completion edge is the edge that enters RESP. With LATENCY=1 this is
  // also the acceptance edge. At that edge the latched fields are not loaded
  // yet, so the live inputs are used instead.
  assign complete = (LAT1 && accept) || ((state == ST_WAIT) && (cnt == 4'd0));

  always_comb begin
    c_wr    = op_wr;
    c_idx   = op_idx;
    c_wdata = op_wdata;
    c_be    = op_be;
    if (state == ST_IDLE) begin
      c_wr    = mem_write;
      c_idx   = mem_address[ADDR_BITS:1];
      c_wdata = mem_wdata;
      c_be    = mem_byte_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      mem_resp   <= 1'b0;
      mem_rdata  <= 16'h0000;
      proto_err  <= 1'b0;
      xact_count <= 16'h0000;
    end else begin
      mem_resp <= complete;
      if (complete && !c_wr) begin
        mem_rdata <= mem_array[c_idx];
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            // Read and write together is treated as a write; odd addresses are
            // served with bit 0 ignored. Both cases flag an error.
            if ((mem_read && mem_write) || mem_address[0]) begin
              proto_err <= 1'b1;
            end
            if (LAT1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          xact_count <= xact_count + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Transaction fields are latched at acceptance. Inputs are ignored until
  // the transaction returns to IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr    <= mem_write;
      op_idx   <= mem_address[ADDR_BITS:1];
      op_wdata <= mem_wdata;
      op_be    <= mem_byte_enable;
    end
  end

  // Array contents survive reset. A reset on the completion edge aborts the
  // write.
  always_ff @(posedge clk) begin
    if (rst_n && complete && c_wr) begin
      if (c_be[0]) mem_array[c_idx][7:0]  <= c_wdata[7:0];
      if (c_be[1]) mem_array[c_idx][15:8] <= c_wdata[15:8];
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder
// Directed bench for lc3b_mem_responder.
// Two instances are used: LATENCY=3 (u_lat3) and LATENCY=1 (u_lat1).
// sel1 routes the request lines to one instance at a time.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        sel1;

  logic        rd1, wr1, rd3, wr3;
  logic        resp1, resp3, perr1, perr3;
  logic [15:0] rdata1, rdata3, xact1, xact3;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_x1 = 16'h0000;
  logic [15:0] exp_x3 = 16'h0000;

  assign rd1 = mem_read  & sel1;
  assign wr1 = mem_write & sel1;
  assign rd3 = mem_read  & ~sel1;
  assign wr3 = mem_write & ~sel1;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd3), .mem_write(wr3),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(resp3), .mem_rdata(rdata3),
    .proto_err(perr3), .xact_count(xact3)
  );

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(resp1), .mem_rdata(rdata1),
    .proto_err(perr1), .xact_count(xact1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  // One CPU-style transaction: the request is held through the resp cycle
  // and dropped after it, unless drop_early is set. exp_rd is the mem_rdata
  // value expected in the resp cycle.
  task automatic run_xact(input string tag, input bit use1, input bit rd, input bit wr,
                          input logic [1:0] be, input logic [15:0] addr,
                          input logic [15:0] wd, input bit drop_early,
                          input logic [15:0] exp_rd);
    int          lat;
    logic [15:0] xb;
    lat  = use1 ? 1 : 3;
    xb   = use1 ? exp_x1 : exp_x3;
    sel1 = use1;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wd;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1 && drop_early) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (k <= lat)
        chk($sformatf("%s:resp@%0d", tag, k), {15'd0, use1 ? resp1 : resp3}, {15'd0, k == lat});
      if (k == lat) begin
        chk({tag, ":rdata"}, use1 ? rdata1 : rdata3, exp_rd);
        chk({tag, ":xact_pre"}, use1 ? xact1 : xact3, xb);
      end
      if (k == lat + 1) begin
        chk({tag, ":resp_off"}, {15'd0, use1 ? resp1 : resp3}, 16'd0);
        chk({tag, ":xact_post"}, use1 ? xact1 : xact3, xb + 16'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
    if (use1) exp_x1 = xb + 16'd1;
    else      exp_x3 = xb + 16'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000; sel1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:resp3",  {15'd0, resp3}, 16'd0);
    chk("rst:rdata3", rdata3, 16'h0000);
    chk("rst:perr3",  {15'd0, perr3}, 16'd0);
    chk("rst:xact3",  xact3, 16'h0000);
    chk("rst:xact1",  xact1, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write and read with LATENCY=3.
    run_xact("wr_beef", 0, 0, 1, 2'b11, 16'h0010, 16'hBEEF, 0, 16'h0000);
    run_xact("rd_beef", 0, 1, 0, 2'b00, 16'h0010, 16'h0000, 0, 16'hBEEF);
    chk("xact_after_two", xact3, 16'd2);

    // Byte masks. On writes, mem_rdata keeps the previous read value.
    run_xact("wr_m01",  0, 0, 1, 2'b01, 16'h0010, 16'h1234, 0, 16'hBEEF);
    run_xact("rd_m01",  0, 1, 0, 2'b00, 16'h0010, 16'h0000, 0, 16'hBE34);
    run_xact("wr_m10",  0, 0, 1, 2'b10, 16'h0010, 16'h5678, 0, 16'hBE34);
    run_xact("rd_m10",  0, 1, 0, 2'b00, 16'h0010, 16'h0000, 0, 16'h5634);
    run_xact("wr_m00",  0, 0, 1, 2'b00, 16'h0010, 16'hFFFF, 0, 16'h5634);
    run_xact("rd_m00",  0, 1, 0, 2'b00, 16'h0010, 16'h0000, 0, 16'h5634);

    // The request is dropped right after acceptance; the transaction still completes.
    run_xact("rd_drop", 0, 1, 0, 2'b00, 16'h0010, 16'h0000, 1, 16'h5634);
    chk("xact_after_drop", xact3, 16'd9);
    chk("perr_clean", {15'd0, perr3}, 16'd0);

    // LATENCY=1 instance: mem_resp in cycle C0+1, with no re-accept on hold.
    run_xact("l1_wr", 1, 0, 1, 2'b11, 16'h0020, 16'hCAFE, 0, 16'h0000);
    run_xact("l1_rd", 1, 1, 0, 2'b00, 16'h0020, 16'h0000, 0, 16'hCAFE);
    chk("l1_xact", xact1, 16'd2);
    chk("l1_perr", {15'd0, perr1}, 16'd0);

    // Read and write together act as a write and set the sticky error flag.
    run_xact("rdwr", 0, 1, 1, 2'b11, 16'h0004, 16'hAAAA, 0, 16'h5634);
    chk("rdwr_perr", {15'd0, perr3}, 16'd1);
    run_xact("rd_odd", 0, 1, 0, 2'b00, 16'h0005, 16'h0000, 0, 16'hAAAA);
    chk("odd_perr", {15'd0, perr3}, 16'd1);

    // Address bits above ADDR_BITS alias.
    run_xact("wr_alias", 0, 0, 1, 2'b11, 16'h0002, 16'h1111, 0, 16'hAAAA);
    run_xact("rd_alias", 0, 1, 0, 2'b00, 16'h0202, 16'h0000, 0, 16'h1111);
    chk("perr_sticky", {15'd0, perr3}, 16'd1);

    // Reset arrives on the completion edge of a write and aborts it.
    run_xact("wr_zero", 0, 0, 1, 2'b11, 16'h0006, 16'h0000, 0, 16'h1111);
    sel1 = 1'b0; mem_write = 1'b1; mem_byte_enable = 2'b11;
    mem_address = 16'h0006; mem_wdata = 16'h2222;
    @(posedge clk); #1;
    mem_write = 1'b0;
    chk("abort:resp_w1", {15'd0, resp3}, 16'd0);
    @(posedge clk); #1;
    chk("abort:resp_w2", {15'd0, resp3}, 16'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort:resp",  {15'd0, resp3}, 16'd0);
    chk("abort:rdata", rdata3, 16'h0000);
    chk("abort:perr",  {15'd0, perr3}, 16'd0);
    chk("abort:xact",  xact3, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort:quiet%0d", i), {15'd0, resp3}, 16'd0);
    end
    exp_x3 = 16'h0000;
    run_xact("rd_after_abort", 0, 1, 0, 2'b00, 16'h0006, 16'h0000, 0, 16'h0000);
    chk("xact_after_abort", xact3, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
